// File: rtl/rv32_encoder_if.sv
// Opcode enumeration shared by the encoder and its users, plus the request/response
// bundle between a producer of decoded fields and the encoder.
package rv32_pkg;
    typedef enum logic [5:0] {
        RV32_UNKNOWN = 6'd0,
        RV32_LUI, RV32_AUIPC, RV32_JAL, RV32_JALR,
        RV32_BEQ, RV32_BNE, RV32_BLT, RV32_BGE, RV32_BLTU, RV32_BGEU,
        RV32_LB, RV32_LH, RV32_LW, RV32_LBU, RV32_LHU,
        RV32_SB, RV32_SH, RV32_SW,
        RV32_ADDI, RV32_SLTI, RV32_SLTIU, RV32_XORI, RV32_ORI, RV32_ANDI,
        RV32_SLLI, RV32_SRLI, RV32_SRAI,
        RV32_ADD, RV32_SUB, RV32_SLL, RV32_SLT, RV32_SLTU,
        RV32_XOR, RV32_SRL, RV32_SRA, RV32_OR, RV32_AND,
        RV32_FENCE, RV32_FENCEI, RV32_ECALL, RV32_EBREAK,
        RV32_CSRRW, RV32_CSRRS, RV32_CSRRC, RV32_CSRRWI, RV32_CSRRSI, RV32_CSRRCI
    } rv32_opcode_enum_t;
endpackage

interface rv32_encoder_if;
    import rv32_pkg::*;
    logic              req_valid;
    logic              req_ready;
    rv32_opcode_enum_t req_opcode;
    logic              req_li;
    logic [4:0]        req_rd;
    logic [4:0]        req_rs1;
    logic [4:0]        req_rs2;
    logic [31:0]       req_imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_instr;
    logic              out_trap;

    modport master (
        output req_valid, req_opcode, req_li, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        input  req_ready, out_valid, out_instr, out_trap
    );
    modport slave (
        input  req_valid, req_opcode, req_li, req_rd, req_rs1, req_rs2, req_imm, out_ready,
        output req_ready, out_valid, out_instr, out_trap
    );
endinterface

// File: rtl/rv32_encoder.sv
// RV32I instruction encoder: decoded fields in, 32-bit machine word out through one
// registered stage. LI with a wide immediate expands into LUI followed by ADDI.
module rv32_encoder
    import rv32_pkg::*;
#(
    parameter bit          EN_LI     = 1'b1,
    parameter logic [7:0]  FENCE_PS  = 8'hFF,
    parameter logic [31:0] TRAP_WORD = 32'h0000_0000
) (
    input  logic           clk,
    input  logic           rst,
    rv32_encoder_if.slave  bus
);
    typedef enum logic { S_IDLE, S_LI2 } state_t;
    typedef enum logic [3:0] { F_R, F_I, F_CSR, F_SH, F_S, F_B, F_U, F_J, F_FIX, F_BAD } fmt_t;

    state_t       state_q, state_d;
    fmt_t         fmt;
    logic [6:0]   opc, f7;
    logic [2:0]   f3;
    logic [31:0]  fix_word, enc_word, addi_word, addi_q, instr_q;
    logic         enc_trap, valid_q, trap_q;
    logic         accept, drain, li_mode, li_two;
    logic         fit12, fitb, fitj;
    logic [19:0]  li_hi;
    logic [31:0]  imm;
    logic [4:0]   rd, rs1, rs2;
    logic signed [31:0] simm;

    assign imm  = bus.req_imm;
    assign simm = $signed(bus.req_imm);
    assign rd   = bus.req_rd;
    assign rs1  = bus.req_rs1;
    assign rs2  = bus.req_rs2;

    assign fit12 = (simm >= -2048) && (simm <= 2047);
    assign fitb  = !imm[0] && (simm >= -4096) && (simm <= 4094);
    assign fitj  = !imm[0] && (simm >= -1048576) && (simm <= 1048574);

    // LUI upper part rounds up when the low 12 bits will be sign-extended negative by ADDI
    assign li_mode   = EN_LI && bus.req_li;
    assign li_hi     = imm[31:12] + {19'b0, imm[11]};
    assign li_two    = li_mode && !fit12 && (imm[11:0] != 12'h000);
    assign addi_word = {imm[11:0], rd, 3'b000, rd, 7'h13};

    always_comb begin
        fmt      = F_BAD;
        opc      = 7'h00;
        f3       = 3'b000;
        f7       = 7'h00;
        fix_word = 32'h0;
        case (bus.req_opcode)
            RV32_LUI:    begin fmt = F_U;   opc = 7'h37; end
            RV32_AUIPC:  begin fmt = F_U;   opc = 7'h17; end
            RV32_JAL:    begin fmt = F_J;   opc = 7'h6F; end
            RV32_JALR:   begin fmt = F_I;   opc = 7'h67; end
            RV32_BEQ:    begin fmt = F_B;   opc = 7'h63; f3 = 3'd0; end
            RV32_BNE:    begin fmt = F_B;   opc = 7'h63; f3 = 3'd1; end
            RV32_BLT:    begin fmt = F_B;   opc = 7'h63; f3 = 3'd4; end
            RV32_BGE:    begin fmt = F_B;   opc = 7'h63; f3 = 3'd5; end
            RV32_BLTU:   begin fmt = F_B;   opc = 7'h63; f3 = 3'd6; end
            RV32_BGEU:   begin fmt = F_B;   opc = 7'h63; f3 = 3'd7; end
            RV32_LB:     begin fmt = F_I;   opc = 7'h03; f3 = 3'd0; end
            RV32_LH:     begin fmt = F_I;   opc = 7'h03; f3 = 3'd1; end
            RV32_LW:     begin fmt = F_I;   opc = 7'h03; f3 = 3'd2; end
            RV32_LBU:    begin fmt = F_I;   opc = 7'h03; f3 = 3'd4; end
            RV32_LHU:    begin fmt = F_I;   opc = 7'h03; f3 = 3'd5; end
            RV32_SB:     begin fmt = F_S;   opc = 7'h23; f3 = 3'd0; end
            RV32_SH:     begin fmt = F_S;   opc = 7'h23; f3 = 3'd1; end
            RV32_SW:     begin fmt = F_S;   opc = 7'h23; f3 = 3'd2; end
            RV32_ADDI:   begin fmt = F_I;   opc = 7'h13; f3 = 3'd0; end
            RV32_SLTI:   begin fmt = F_I;   opc = 7'h13; f3 = 3'd2; end
            RV32_SLTIU:  begin fmt = F_I;   opc = 7'h13; f3 = 3'd3; end
            RV32_XORI:   begin fmt = F_I;   opc = 7'h13; f3 = 3'd4; end
            RV32_ORI:    begin fmt = F_I;   opc = 7'h13; f3 = 3'd6; end
            RV32_ANDI:   begin fmt = F_I;   opc = 7'h13; f3 = 3'd7; end
            RV32_SLLI:   begin fmt = F_SH;  opc = 7'h13; f3 = 3'd1; end
            RV32_SRLI:   begin fmt = F_SH;  opc = 7'h13; f3 = 3'd5; end
            RV32_SRAI:   begin fmt = F_SH;  opc = 7'h13; f3 = 3'd5; f7 = 7'h20; end
            RV32_ADD:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd0; end
            RV32_SUB:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd0; f7 = 7'h20; end
            RV32_SLL:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd1; end
            RV32_SLT:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd2; end
            RV32_SLTU:   begin fmt = F_R;   opc = 7'h33; f3 = 3'd3; end
            RV32_XOR:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd4; end
            RV32_SRL:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd5; end
            RV32_SRA:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd5; f7 = 7'h20; end
            RV32_OR:     begin fmt = F_R;   opc = 7'h33; f3 = 3'd6; end
            RV32_AND:    begin fmt = F_R;   opc = 7'h33; f3 = 3'd7; end
            RV32_FENCE:  begin fmt = F_FIX; fix_word = {4'b0, FENCE_PS, 20'h0000F}; end
            RV32_FENCEI: begin fmt = F_FIX; fix_word = 32'h0000_100F; end
            RV32_ECALL:  begin fmt = F_FIX; fix_word = 32'h0000_0073; end
            RV32_EBREAK: begin fmt = F_FIX; fix_word = 32'h0010_0073; end
            RV32_CSRRW:  begin fmt = F_CSR; opc = 7'h73; f3 = 3'd1; end
            RV32_CSRRS:  begin fmt = F_CSR; opc = 7'h73; f3 = 3'd2; end
            RV32_CSRRC:  begin fmt = F_CSR; opc = 7'h73; f3 = 3'd3; end
            RV32_CSRRWI: begin fmt = F_CSR; opc = 7'h73; f3 = 3'd5; end
            RV32_CSRRSI: begin fmt = F_CSR; opc = 7'h73; f3 = 3'd6; end
            RV32_CSRRCI: begin fmt = F_CSR; opc = 7'h73; f3 = 3'd7; end
            default:     fmt = F_BAD;
        endcase
    end

    // Any format whose range check fails falls through to the trap word
    always_comb begin
        enc_word = TRAP_WORD;
        enc_trap = 1'b1;
        case (fmt)
            F_R:   begin enc_word = {f7, rs2, rs1, f3, rd, opc}; enc_trap = 1'b0; end
            F_I:   if (fit12) begin enc_word = {imm[11:0], rs1, f3, rd, opc}; enc_trap = 1'b0; end
            F_CSR: begin enc_word = {imm[11:0], rs1, f3, rd, opc}; enc_trap = 1'b0; end
            F_SH:  begin enc_word = {f7, imm[4:0], rs1, f3, rd, opc}; enc_trap = 1'b0; end
            F_S:   if (fit12) begin
                       enc_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc}; enc_trap = 1'b0;
                   end
            F_B:   if (fitb) begin
                       enc_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
                       enc_trap = 1'b0;
                   end
            F_U:   begin enc_word = {imm[31:12], rd, opc}; enc_trap = 1'b0; end
            F_J:   if (fitj) begin
                       enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
                       enc_trap = 1'b0;
                   end
            F_FIX: begin enc_word = fix_word; enc_trap = 1'b0; end
            default: ;
        endcase
        if (li_mode) begin
            enc_trap = 1'b0;
            enc_word = fit12 ? {imm[11:0], 5'd0, 3'b000, rd, 7'h13} : {li_hi, rd, 7'h37};
        end
    end

    assign drain         = valid_q && bus.out_ready;
    assign bus.req_ready = (state_q == S_IDLE) && (!valid_q || bus.out_ready);
    assign accept        = bus.req_valid && bus.req_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept && li_two) state_d = S_LI2;
            S_LI2:   if (drain) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // While in LI2 the output register is always full with the LUI word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            trap_q  <= 1'b0;
            addi_q  <= 32'h0;
        end else if (state_q == S_LI2) begin
            if (drain) begin
                instr_q <= addi_q;
                trap_q  <= 1'b0;
            end
        end else if (accept) begin
            valid_q <= 1'b1;
            instr_q <= enc_word;
            trap_q  <= enc_trap;
            if (li_two) addi_q <= addi_word;
        end else if (drain) begin
            valid_q <= 1'b0;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_trap  = trap_q;
endmodule

// File: tb/tb_rv32_encoder.sv
// Bench for rv32_encoder: directed spec vectors, stall/back-to-back ordering, async
// reset during LI expansion, and a randomized stream scored against a word-level model.
module tb_rv32_encoder;
    import rv32_pkg::*;

    localparam logic [31:0] TRAP = 32'h0BAD_F00D;

    typedef struct {
        bit          v;
        bit          ordy;
        logic [31:0] w;
        logic        t;
        bit          rr;
        bit          acc;
    } snap_t;

    typedef struct {
        rv32_opcode_enum_t op;
        bit                li;
        logic [4:0]        rd, rs1, rs2;
        logic [31:0]       imm;
        int                n;
        logic [31:0]       w0, w1;
        bit                trap;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    bit [32:0] exp_q[$];

    rv32_encoder_if bus();

    rv32_encoder #(.EN_LI(1'b1), .FENCE_PS(8'hFF), .TRAP_WORD(TRAP)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // Expected word stream for one accepted request, built from the instruction formats
    function automatic void model(rv32_opcode_enum_t op, bit li, logic [4:0] rd_i,
                                  logic [4:0] rs1_i, logic [4:0] rs2_i, logic [31:0] imm);
        int        si;
        bit [31:0] d, s1, s2, w, base, u, hi;
        byte       fmt;
        bit        ok;
        si = $signed(imm);
        d = 32'(rd_i); s1 = 32'(rs1_i); s2 = 32'(rs2_i); u = imm;
        if (li) begin
            if (si >= -2048 && si <= 2047) begin
                w = ((u & 32'hFFF) << 20) | (d << 7) | 32'h13;
                exp_q.push_back({1'b0, w});
            end else begin
                hi = (u + 32'h800) & 32'hFFFF_F000;
                w  = hi | (d << 7) | 32'h37;
                exp_q.push_back({1'b0, w});
                if ((u & 32'hFFF) != 0) begin
                    w = ((u & 32'hFFF) << 20) | (d << 15) | (d << 7) | 32'h13;
                    exp_q.push_back({1'b0, w});
                end
            end
            return;
        end
        fmt = 0; base = 0;
        case (op)
            RV32_LUI:    begin fmt = "U"; base = 32'h37; end
            RV32_AUIPC:  begin fmt = "U"; base = 32'h17; end
            RV32_JAL:    begin fmt = "J"; base = 32'h6F; end
            RV32_JALR:   begin fmt = "I"; base = 32'h67; end
            RV32_BEQ:    begin fmt = "B"; base = 32'h0063; end
            RV32_BNE:    begin fmt = "B"; base = 32'h1063; end
            RV32_BLT:    begin fmt = "B"; base = 32'h4063; end
            RV32_BGE:    begin fmt = "B"; base = 32'h5063; end
            RV32_BLTU:   begin fmt = "B"; base = 32'h6063; end
            RV32_BGEU:   begin fmt = "B"; base = 32'h7063; end
            RV32_LB:     begin fmt = "I"; base = 32'h0003; end
            RV32_LH:     begin fmt = "I"; base = 32'h1003; end
            RV32_LW:     begin fmt = "I"; base = 32'h2003; end
            RV32_LBU:    begin fmt = "I"; base = 32'h4003; end
            RV32_LHU:    begin fmt = "I"; base = 32'h5003; end
            RV32_SB:     begin fmt = "S"; base = 32'h0023; end
            RV32_SH:     begin fmt = "S"; base = 32'h1023; end
            RV32_SW:     begin fmt = "S"; base = 32'h2023; end
            RV32_ADDI:   begin fmt = "I"; base = 32'h0013; end
            RV32_SLTI:   begin fmt = "I"; base = 32'h2013; end
            RV32_SLTIU:  begin fmt = "I"; base = 32'h3013; end
            RV32_XORI:   begin fmt = "I"; base = 32'h4013; end
            RV32_ORI:    begin fmt = "I"; base = 32'h6013; end
            RV32_ANDI:   begin fmt = "I"; base = 32'h7013; end
            RV32_SLLI:   begin fmt = "H"; base = 32'h1013; end
            RV32_SRLI:   begin fmt = "H"; base = 32'h5013; end
            RV32_SRAI:   begin fmt = "H"; base = 32'h4000_5013; end
            RV32_ADD:    begin fmt = "R"; base = 32'h0033; end
            RV32_SUB:    begin fmt = "R"; base = 32'h4000_0033; end
            RV32_SLL:    begin fmt = "R"; base = 32'h1033; end
            RV32_SLT:    begin fmt = "R"; base = 32'h2033; end
            RV32_SLTU:   begin fmt = "R"; base = 32'h3033; end
            RV32_XOR:    begin fmt = "R"; base = 32'h4033; end
            RV32_SRL:    begin fmt = "R"; base = 32'h5033; end
            RV32_SRA:    begin fmt = "R"; base = 32'h4000_5033; end
            RV32_OR:     begin fmt = "R"; base = 32'h6033; end
            RV32_AND:    begin fmt = "R"; base = 32'h7033; end
            RV32_FENCE:  begin fmt = "X"; base = 32'h0FF0_000F; end
            RV32_FENCEI: begin fmt = "X"; base = 32'h0000_100F; end
            RV32_ECALL:  begin fmt = "X"; base = 32'h0000_0073; end
            RV32_EBREAK: begin fmt = "X"; base = 32'h0010_0073; end
            RV32_CSRRW:  begin fmt = "C"; base = 32'h1073; end
            RV32_CSRRS:  begin fmt = "C"; base = 32'h2073; end
            RV32_CSRRC:  begin fmt = "C"; base = 32'h3073; end
            RV32_CSRRWI: begin fmt = "C"; base = 32'h5073; end
            RV32_CSRRSI: begin fmt = "C"; base = 32'h6073; end
            RV32_CSRRCI: begin fmt = "C"; base = 32'h7073; end
            default:     fmt = 0;
        endcase
        ok = 1'b1; w = 0;
        case (fmt)
            "R": w = base | (s2 << 20) | (s1 << 15) | (d << 7);
            "I": begin ok = si >= -2048 && si <= 2047; w = base | ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7); end
            "C": w = base | ((u & 32'hFFF) << 20) | (s1 << 15) | (d << 7);
            "H": w = base | ((u & 32'h1F) << 20) | (s1 << 15) | (d << 7);
            "S": begin
                ok = si >= -2048 && si <= 2047;
                w = base | (((u >> 5) & 32'h7F) << 25) | (s2 << 20) | (s1 << 15) | ((u & 32'h1F) << 7);
            end
            "B": begin
                ok = (si % 2 == 0) && si >= -4096 && si <= 4094;
                w = base | (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3F) << 25) | (s2 << 20) | (s1 << 15)
                         | (((u >> 1) & 32'hF) << 8) | (((u >> 11) & 1) << 7);
            end
            "U": w = base | (u & 32'hFFFF_F000) | (d << 7);
            "J": begin
                ok = (si % 2 == 0) && si >= -1048576 && si <= 1048574;
                w = base | (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3FF) << 21) | (((u >> 11) & 1) << 20)
                         | (((u >> 12) & 32'hFF) << 12) | (d << 7);
            end
            "X": w = base;
            default: ok = 1'b0;
        endcase
        exp_q.push_back(ok ? {1'b0, w} : {1'b1, TRAP});
    endfunction

    task automatic set_req(rv32_opcode_enum_t op, bit li, logic [4:0] rd_i, logic [4:0] rs1_i,
                           logic [4:0] rs2_i, logic [31:0] imm, bit v);
        bus.req_opcode = op; bus.req_li = li; bus.req_rd = rd_i;
        bus.req_rs1 = rs1_i; bus.req_rs2 = rs2_i; bus.req_imm = imm; bus.req_valid = v;
    endtask

    task automatic rand_req(bit allow_li, bit v);
        logic [31:0] edge_imm [16] = '{32'd2047, 32'd2048, -32'sd2048, -32'sd2049, 32'd4094, 32'd4096,
                                       -32'sd4096, -32'sd4098, 32'd3, 32'h7FFF_F800, 32'hFFFF_F800,
                                       32'h1234_5000, 32'd1048574, -32'sd1048576, 32'd1048576, 32'h0};
        logic [31:0] imm;
        case ($urandom_range(0, 2))
            0: imm = edge_imm[$urandom_range(0, 15)];
            1: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            default: imm = $urandom;
        endcase
        set_req(rv32_opcode_enum_t'(6'($urandom_range(0, 63))), allow_li && ($urandom_range(0, 3) == 0),
                5'($urandom), 5'($urandom), 5'($urandom), imm, v);
    endtask

    // One clock: sample at the falling edge, score any accept, return just after the rising edge
    task automatic tick(output snap_t s);
        @(negedge clk);
        s.v = bus.out_valid; s.ordy = bus.out_ready; s.w = bus.out_instr; s.t = bus.out_trap;
        s.rr = bus.req_ready; s.acc = bus.req_valid && bus.req_ready;
        if (s.acc) model(bus.req_opcode, bus.req_li, bus.req_rd, bus.req_rs1, bus.req_rs2, bus.req_imm);
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        set_req(RV32_UNKNOWN, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", bus.out_instr); end
        checks++; if (bus.out_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got=%b want=0", bus.out_trap); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", bus.req_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_directed;
        vec_t  vt[11];
        snap_t s;
        vt[0]  = '{RV32_ADD,    0, 5'd3, 5'd1, 5'd2, 32'd0,         1, 32'h002081B3, 32'h0, 0};
        vt[1]  = '{RV32_ADD,    1, 5'd5, 5'd0, 5'd0, 32'h12345678,  2, 32'h123452B7, 32'h67828293, 0};
        vt[2]  = '{RV32_ADD,    1, 5'd5, 5'd0, 5'd0, 32'hFFFFF800,  1, 32'h80000293, 32'h0, 0};
        vt[3]  = '{RV32_ADD,    1, 5'd5, 5'd0, 5'd0, 32'h00012000,  1, 32'h000122B7, 32'h0, 0};
        vt[4]  = '{RV32_BEQ,    0, 5'd0, 5'd1, 5'd2, -32'sd4,       1, 32'hFE208EE3, 32'h0, 0};
        vt[5]  = '{RV32_BEQ,    0, 5'd0, 5'd1, 5'd2, 32'd3,         1, TRAP,         32'h0, 1};
        vt[6]  = '{RV32_ADDI,   0, 5'd1, 5'd1, 5'd0, 32'd2048,      1, TRAP,         32'h0, 1};
        vt[7]  = '{RV32_ECALL,  0, 5'd0, 5'd0, 5'd0, 32'd0,         1, 32'h00000073, 32'h0, 0};
        vt[8]  = '{RV32_ADD,    1, 5'd5, 5'd0, 5'd0, 32'h7FFFF800,  2, 32'h800002B7, 32'h80028293, 0};
        vt[9]  = '{RV32_FENCE,  0, 5'd0, 5'd0, 5'd0, 32'd0,         1, 32'h0FF0000F, 32'h0, 0};
        vt[10] = '{RV32_SRAI,   0, 5'd1, 5'd2, 5'd0, 32'd3,         1, 32'h40315093, 32'h0, 0};
        bus.out_ready = 1'b1;
        foreach (vt[i]) begin
            set_req(vt[i].op, vt[i].li, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, 1'b1);
            tick(s);
            checks++; if (!s.acc) begin errors++; $display("FAIL dir%0d_accept got=0 want=1", i); end
            bus.req_valid = 1'b0;
            for (int k = 0; k < vt[i].n; k++) begin
                tick(s);
                checks++;
                if (s.v !== 1'b1 || s.w !== (k == 0 ? vt[i].w0 : vt[i].w1) || s.t !== vt[i].trap) begin
                    errors++;
                    $display("FAIL dir%0d_word%0d got v=%b w=%h t=%b want v=1 w=%h t=%b", i, k, s.v, s.w, s.t,
                             (k == 0 ? vt[i].w0 : vt[i].w1), vt[i].trap);
                end
                if (vt[i].n == 2 && k == 0) begin
                    checks++; if (s.rr !== 1'b0) begin errors++; $display("FAIL dir%0d_li2_ready got=%b want=0", i, s.rr); end
                end
            end
            tick(s);
            checks++; if (s.v !== 1'b0) begin errors++; $display("FAIL dir%0d_extra_word got v=%b w=%h want v=0", i, s.v, s.w); end
        end
        exp_q.delete();
    endtask

    task automatic test_back_to_back;
        snap_t       s;
        bit [32:0]   e;
        logic [31:0] held_w;
        logic        held_t;
        int          sent = 0, got = 0, c = 0;
        exp_q.delete();
        rand_req(1'b0, 1'b1);
        while (got < 9 && c < 40) begin
            bus.out_ready = (c >= 5);
            if (sent >= 9) bus.req_valid = 1'b0;
            tick(s);
            if (c == 1) begin held_w = s.w; held_t = s.t; end
            if (c >= 2 && c <= 4) begin
                checks++;
                if (s.v !== 1'b1 || s.w !== held_w || s.t !== held_t || s.rr !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_hold c=%0d got v=%b w=%h t=%b rdy=%b want v=1 w=%h t=%b rdy=0",
                             c, s.v, s.w, s.t, s.rr, held_w, held_t);
                end
            end
            if (s.v && s.ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra got w=%h want none", s.w);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.t, s.w} !== e) begin
                        errors++; $display("FAIL b2b_word%0d got t=%b w=%h want t=%b w=%h", got, s.t, s.w, e[32], e[31:0]);
                    end
                end
                got++;
            end
            if (s.acc) begin
                sent++;
                if (sent < 9) rand_req(1'b0, 1'b1);
            end
            c++;
        end
        bus.req_valid = 1'b0;
        checks++; if (c != 14) begin errors++; $display("FAIL b2b_rate got cycles=%0d want 14", c); end
    endtask

    task automatic test_reset_mid_li;
        snap_t s;
        exp_q.delete();
        bus.out_ready = 1'b0;
        set_req(RV32_ADD, 1'b1, 5'd5, 5'd0, 5'd0, 32'h12345678, 1'b1);
        tick(s);
        bus.req_valid = 1'b0;
        tick(s);
        checks++;
        if (s.v !== 1'b1 || s.w !== 32'h123452B7 || s.rr !== 1'b0) begin
            errors++; $display("FAIL li2_hold got v=%b w=%h rdy=%b want v=1 w=123452b7 rdy=0", s.v, s.w, s.rr);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin
            errors++; $display("FAIL async_reset got v=%b w=%h want v=0 w=0", bus.out_valid, bus.out_instr);
        end
        #1 rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(s);
            checks++;
            if (s.v !== 1'b0 || s.rr !== 1'b1) begin
                errors++; $display("FAIL no_addi_after_reset got v=%b w=%h rdy=%b want v=0 rdy=1", s.v, s.w, s.rr);
            end
        end
        set_req(RV32_ECALL, 1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);
        tick(s);
        bus.req_valid = 1'b0;
        tick(s);
        checks++;
        if (s.v !== 1'b1 || s.w !== 32'h00000073 || s.t !== 1'b0) begin
            errors++; $display("FAIL ecall_after_reset got v=%b w=%h t=%b want v=1 w=00000073 t=0", s.v, s.w, s.t);
        end
        tick(s);
        exp_q.delete();
    endtask

    task automatic test_random;
        snap_t       s;
        bit [32:0]   e;
        bit          held = 0;
        logic [31:0] hw = 0;
        logic        ht = 0;
        int          c = 0;
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            rand_req(1'b1, $urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick(s);
            if (held) begin
                checks++;
                if (s.v !== 1'b1 || s.w !== hw || s.t !== ht) begin
                    errors++; $display("FAIL rand_stall_stable got v=%b w=%h t=%b want v=1 w=%h t=%b", s.v, s.w, s.t, hw, ht);
                end
            end
            held = s.v && !s.ordy; hw = s.w; ht = s.t;
            if (s.v && s.ordy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rand_extra got w=%h want none", s.w);
                end else begin
                    e = exp_q.pop_front();
                    if ({s.t, s.w} !== e) begin
                        errors++; $display("FAIL rand_word got t=%b w=%h want t=%b w=%h", s.t, s.w, e[32], e[31:0]);
                    end
                end
            end
        end
        bus.req_valid = 1'b0;
        bus.out_ready = 1'b1;
        while (exp_q.size() > 0 && c < 20) begin
            tick(s);
            if (s.v) begin
                e = exp_q.pop_front();
                checks++;
                if ({s.t, s.w} !== e) begin
                    errors++; $display("FAIL rand_drain got t=%b w=%h want t=%b w=%h", s.t, s.w, e[32], e[31:0]);
                end
            end
            c++;
        end
        tick(s);
        checks++;
        if (exp_q.size() != 0 || s.v !== 1'b0) begin
            errors++; $display("FAIL rand_leftover got pending=%0d v=%b want pending=0 v=0", exp_q.size(), s.v);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_li();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
